// File: rtl/zbb_bitcnt_pkg.sv
// Shared types for the Zbb bit-count unit (CLZ/CTZ/CPOP).
// Optional feature macro used by the top: ZBB_BITCNT_EARLY_EXIT_EN.
package zbb_bitcnt_pkg;

  // Integer datapath width of the core.
  localparam int RISCV_ARCH = 64;

  // Chunk counter covers up to RISCV_ARCH chunks (CHUNK_BITS=1).
  localparam int CNT_W = $clog2(RISCV_ARCH) + 1;
  // A count of RISCV_ARCH needs one more bit than its index range.
  localparam int ACC_W = $clog2(RISCV_ARCH) + 1;

  // Bit positions inside the one-hot mode vector.
  localparam int BITCNT_CLZ  = 0;
  localparam int BITCNT_CTZ  = 1;
  localparam int BITCNT_CPOP = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    state_e                  state;
    logic [2:0]              mode;
    logic                    rv32;
    logic [RISCV_ARCH-1:0]   scan;
    logic [CNT_W-1:0]        cnt;
    logic [ACC_W-1:0]        acc;
    logic                    found;
    logic [RISCV_ARCH-1:0]   res;
    logic                    valid;
  } zbb_bitcnt_registers;

  localparam zbb_bitcnt_registers zbb_bitcnt_r_reset = '{
    state: IDLE,
    mode:  3'b000,
    rv32:  1'b0,
    scan:  '0,
    cnt:   '0,
    acc:   '0,
    found: 1'b0,
    res:   '0,
    valid: 1'b0
  };

  // Reverse the operand within its active width so CLZ can be scanned LSB-first.
  function automatic logic [RISCV_ARCH-1:0] bit_reverse(input logic [RISCV_ARCH-1:0] a,
                                                         input logic w32);
    logic [RISCV_ARCH-1:0] rev;
    rev = '0;
    if (w32) begin
      for (int i = 0; i < 32; i++) rev[i] = a[31-i];
    end else begin
      for (int i = 0; i < RISCV_ARCH; i++) rev[i] = a[RISCV_ARCH-1-i];
    end
    return rev;
  endfunction

endpackage

// File: rtl/zbb_bitcnt_chunk_count.sv
// Combinational per-chunk counters: trailing-zero count and population count.
// tz reports CHUNK_BITS for an all-zero chunk so it can be accumulated directly.
module zbb_chunk_count
  import zbb_bitcnt_pkg::*;
#(
  parameter int CHUNK_BITS = 8,
  localparam int CW = $clog2(CHUNK_BITS) + 1
) (
  input  logic [CHUNK_BITS-1:0] chunk,
  output logic [CW-1:0]         tz,
  output logic [CW-1:0]         pop
);

  // Lowest set bit wins because the scan runs from the top down.
  always_comb begin
    tz = CW'(CHUNK_BITS);
    for (int i = CHUNK_BITS - 1; i >= 0; i--) begin
      if (chunk[i]) tz = CW'(i);
    end
  end

  // Straight sum of the chunk's bits.
  always_comb begin
    pop = '0;
    for (int i = 0; i < CHUNK_BITS; i++) begin
      pop = pop + CW'(chunk[i]);
    end
  end

endmodule

// File: rtl/zbb_bitcnt.sv
// Multi-cycle Zbb bit-count unit: CLZ/CTZ/CPOP and their W variants.
// The operand is scanned LSB-first, CHUNK_BITS per busy cycle; CLZ is turned
// into a trailing-zero scan by bit-reversing the operand at capture.
// Optional macro ZBB_BITCNT_EARLY_EXIT_EN: CLZ/CTZ finish on the first nonzero chunk.
module zbb_bitcnt
  import zbb_bitcnt_pkg::*;
#(
  parameter int CHUNK_BITS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_ena,
  input  logic [2:0]            i_mode,
  input  logic                  i_rv32,
  input  logic [RISCV_ARCH-1:0] i_a1,
  output logic [RISCV_ARCH-1:0] o_res,
  output logic                  o_valid,
  output logic                  o_busy
);

  localparam int CW = $clog2(CHUNK_BITS) + 1;
  localparam logic [CNT_W-1:0] CHUNKS_64 = CNT_W'(RISCV_ARCH / CHUNK_BITS);
  localparam logic [CNT_W-1:0] CHUNKS_32 = CNT_W'(32 / CHUNK_BITS);

  zbb_bitcnt_registers r;
  zbb_bitcnt_registers v;

  logic [CHUNK_BITS-1:0] chunk;
  logic [CW-1:0]         chunk_tz;
  logic [CW-1:0]         chunk_pop;
  logic [ACC_W-1:0]      acc_next;
  logic                  found_next;
  logic                  last;
  logic                  tz_mode;
  logic [RISCV_ARCH-1:0] operand;

  zbb_chunk_count #(
    .CHUNK_BITS(CHUNK_BITS)
  ) u_chunk (
    .chunk(chunk),
    .tz   (chunk_tz),
    .pop  (chunk_pop)
  );

  // Next-state computation: capture, per-chunk accumulation and result publish.
  always_comb begin
    v          = r;
    v.valid    = 1'b0;
    chunk      = r.scan[CHUNK_BITS-1:0];
    acc_next   = r.acc;
    found_next = r.found;
    last       = 1'b0;
    tz_mode    = r.mode[BITCNT_CLZ] | r.mode[BITCNT_CTZ];
    operand    = i_rv32 ? {{(RISCV_ARCH-32){1'b0}}, i_a1[31:0]} : i_a1;

    case (r.state)
      IDLE, DONE: begin
        v.state = IDLE;
        if (i_ena) begin
          v.state = BUSY;
          v.mode  = i_mode;
          v.rv32  = i_rv32;
          v.scan  = i_mode[BITCNT_CLZ] ? bit_reverse(operand, i_rv32) : operand;
          v.cnt   = i_rv32 ? CHUNKS_32 : CHUNKS_64;
          v.acc   = '0;
          v.found = 1'b0;
        end
      end
      BUSY: begin
        if (r.mode[BITCNT_CPOP]) begin
          acc_next = r.acc + ACC_W'(chunk_pop);
        end else if (!r.found) begin
          acc_next   = r.acc + ACC_W'(chunk_tz);
          found_next = |chunk;
        end
        last = (r.cnt == CNT_W'(1));
`ifdef ZBB_BITCNT_EARLY_EXIT_EN
        if (!r.mode[BITCNT_CPOP] && !r.found && (|chunk)) last = 1'b1;
`endif
        v.scan  = r.scan >> CHUNK_BITS;
        v.cnt   = r.cnt - CNT_W'(1);
        v.acc   = acc_next;
        v.found = found_next;
        if (last) begin
          v.state = DONE;
          v.valid = 1'b1;
          v.res   = RISCV_ARCH'(acc_next);
          // An all-zero operand reports its width directly.
          if (tz_mode && !found_next) begin
            v.res = r.rv32 ? RISCV_ARCH'(32) : RISCV_ARCH'(RISCV_ARCH);
          end
        end
      end
      default: v.state = IDLE;
    endcase
  end

  // Register bank with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r <= zbb_bitcnt_r_reset;
    else         r <= v;
  end

  assign o_res   = r.res;
  assign o_valid = r.valid;
  assign o_busy  = (r.state == BUSY);

endmodule

// File: tb/tb_zbb_bitcnt.sv
// Bench for zbb_bitcnt: directed vectors, a behavioural count/latency model and
// a per-cycle output checker. Honors ZBB_BITCNT_EARLY_EXIT_EN for expected latency.
module tb_zbb_bitcnt;
  import zbb_bitcnt_pkg::*;

`ifdef ZBB_BITCNT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [2:0] M_CLZ  = 3'b001;
  localparam logic [2:0] M_CTZ  = 3'b010;
  localparam logic [2:0] M_CPOP = 3'b100;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ena;
  logic [2:0]  mode;
  logic        rv32;
  logic [63:0] a1;
  logic [63:0] res;
  logic        valid;
  logic        busy;

  always #5 clk = ~clk;

  zbb_bitcnt #(.CHUNK_BITS(8)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .i_ena  (ena),
    .i_mode (mode),
    .i_rv32 (rv32),
    .i_a1   (a1),
    .o_res  (res),
    .o_valid(valid),
    .o_busy (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          issue;
    int          done;
    logic [63:0] val;
  } exp_t;

  exp_t        q[$];
  logic [63:0] held = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Count defined directly from the instruction semantics.
  function automatic int ref_count(input logic [2:0] m, input logic w32, input logic [63:0] a);
    int w;
    int n;
    w = w32 ? 32 : 64;
    n = 0;
    if (m[2]) begin
      for (int i = 0; i < w; i++) n += int'(a[i]);
    end else if (m[1]) begin
      n = w;
      for (int i = w - 1; i >= 0; i--) if (a[i]) n = i;
    end else begin
      n = w;
      for (int i = 0; i < w; i++) if (a[i]) n = w - 1 - i;
    end
    return n;
  endfunction

  // Cycles from the i_ena cycle to the o_valid cycle.
  function automatic int ref_latency(input logic [2:0] m, input logic w32, input logic [63:0] a);
    int w;
    int c;
    w = w32 ? 32 : 64;
    c = ref_count(m, w32, a);
    if (EARLY && !m[2] && c < w) return c / 8 + 2;
    return w / 8 + 1;
  endfunction

  // Per-cycle output checker against the expected-result queue.
  always @(negedge clk) begin
    bit busy_exp;
    if (!nrst) begin
      check("reset_valid", {63'd0, valid}, 64'd0);
      check("reset_res", res, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
    end else begin
      busy_exp = (q.size() > 0) && (cyc > q[0].issue) && (cyc < q[0].done);
      check("busy", {63'd0, busy}, {63'd0, busy_exp});
      if (q.size() > 0 && cyc == q[0].done) begin
        check("valid_pulse", {63'd0, valid}, 64'd1);
        check("result", res, q[0].val);
        held = q[0].val;
        void'(q.pop_front());
      end else begin
        check("valid_idle", {63'd0, valid}, 64'd0);
        check("res_held", res, held);
      end
    end
  end

  // Drive one issue cycle; record the expectation when the unit can accept it.
  task automatic issue(input logic [2:0] m, input logic w32, input logic [63:0] a);
    exp_t e;
    bit   accept;
    mode = m;
    rv32 = w32;
    a1   = a;
    ena  = 1'b1;
    accept = !((q.size() > 0) && (cyc > q[$].issue) && (cyc < q[$].done));
    if (accept) begin
      e.issue = cyc;
      e.done  = cyc + ref_latency(m, w32, a);
      e.val   = 64'(ref_count(m, w32, a));
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    ena = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int at);
    int n;
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (valid !== 1'b1) check({name, "_timeout"}, 64'd0, 64'd1);
    at = cyc;
  endtask

  // Directed op with literal expected value and latency that also pin the model.
  task automatic run_op(input string name, input logic [2:0] m, input logic w32,
                        input logic [63:0] a, input int exp_val, input int lat_fixed,
                        input int lat_early);
    int start;
    int at;
    int lat;
    lat = EARLY ? lat_early : lat_fixed;
    check({name, "_model"}, 64'(ref_count(m, w32, a)), 64'(exp_val));
    check({name, "_model_lat"}, 64'(ref_latency(m, w32, a)), 64'(lat));
    start = cyc;
    issue(m, w32, a);
    wait_valid(name, at);
    check({name, "_res"}, res, 64'(exp_val));
    check({name, "_lat"}, 64'(at - start), 64'(lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int at;
    int start;
    int n;
    nrst = 1'b0;
    ena  = 1'b0;
    mode = M_CTZ;
    rv32 = 1'b0;
    a1   = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_res", res, 64'd0);
    check("post_reset_valid", {63'd0, valid}, 64'd0);

    run_op("ctz_100",      M_CTZ,  1'b0, 64'h100,                8,  9, 3);
    run_op("clz_1",        M_CLZ,  1'b0, 64'h1,                  63, 9, 9);
    run_op("clz_msb",      M_CLZ,  1'b0, 64'h8000_0000_0000_0000, 0, 9, 2);
    run_op("cpop_ones",    M_CPOP, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64, 9, 9);
    run_op("cpopw",        M_CPOP, 1'b1, 64'hFFFF_FFFF_0000_00F0, 4,  5, 5);
    run_op("clzw_zero",    M_CLZ,  1'b1, 64'hFFFF_FFFF_0000_0000, 32, 5, 5);
    run_op("ctz_zero",     M_CTZ,  1'b0, 64'h0,                  64, 9, 9);
    run_op("ctzw_zero",    M_CTZ,  1'b1, 64'h0000_0001_0000_0000, 32, 5, 5);
    run_op("cpop_mix",     M_CPOP, 1'b0, 64'h0123_4567_89AB_CDEF, 32, 9, 9);
    run_op("clz_mid",      M_CLZ,  1'b0, 64'h0000_0000_00F0_0000, 40, 9, 7);
    run_op("ctz_msb",      M_CTZ,  1'b0, 64'h8000_0000_0000_0000, 63, 9, 9);
    run_op("clzw_1",       M_CLZ,  1'b1, 64'hFFFF_FFFF_0000_0001, 31, 5, 5);

    // i_ena while busy is dropped: only the first result appears.
    issue(M_CTZ, 1'b0, 64'h100);
    issue(M_CPOP, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    n = 0;
    while (q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ignore_drained", 64'(q.size()), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    check("ignore_res", res, 64'd8);

    // Back-to-back: issue again in the o_valid cycle.
    issue(M_CTZ, 1'b0, 64'h100);
    wait_valid("b2b_first", at);
    check("b2b_first_res", res, 64'd8);
    start = cyc;
    issue(M_CPOP, 1'b0, 64'h0F);
    wait_valid("b2b_second", at);
    check("b2b_second_res", res, 64'd4);
    check("b2b_second_lat", 64'(at - start), 64'd9);
    @(posedge clk);
    #1;

    // Reset mid-operation aborts without a result.
    issue(M_CPOP, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (3) @(posedge clk);
    #3;
    nrst = 1'b0;
    q.delete();
    held = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_res", res, 64'd0);
    check("abort_valid", {63'd0, valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
